hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
- Sequences the ID-stage stall and flush decisions for the 5-stage MIPS pipeline.
- Decides how many bubble cycles to insert for load-use and branch-operand hazards. Branch operands can only be forwarded into ID from MEM/WB, so these hazards cannot be forwarded away.
- Freezes the whole pipe on a memory stall and flushes IF/ID on a taken branch.
- Keeps saturating performance counters for stall cycles and flushes.

Parameters:
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ID_EX_MemRead  in  1  the instruction in EX is a load.
- ID_EX_RegWrite  in  1  the instruction in EX writes a register.
- ID_EX_RegisterRd  in  5  final destination register of the EX instruction, after the RegDst mux.
- EX_MEM_RegWrite  in  1  the instruction in MEM writes a register.
- EX_MEM_RegisterRd  in  5  destination register of the MEM instruction.
- IF_ID_RegisterRs  in  5  Rs field of the instruction in ID.
- IF_ID_RegisterRt  in  5  Rt field of the instruction in ID.
- ID_UsesRt  in  1  the ID instruction reads Rt as a source.
- ID_Branch  in  1  the ID instruction is beq, bne or jr and resolves in ID.
- ID_BranchTaken  in  1  branch/jump outcome computed in ID.
- mem_stall  in  1  I-cache or D-cache miss in progress.
- perf_clr  in  1  synchronous clear of both counters.
- PC_Write  out  1  enables the PC update.
- IF_ID_Write  out  1  enables the IF/ID register update.
- ID_EX_Bubble  out  1  zeroes the ID/EX control bits.
- IF_ID_Flush  out  1  clears IF/ID.
- Pipe_Freeze  out  1  holds ID/EX, EX/MEM and MEM/WB.
- stall_cycles  out  CNT_W  saturating count of hazard stall cycles.
- flush_count  out  CNT_W  saturating count of IF/ID flushes.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=RUN, cnt=0, both counters 0.
  - Outputs forced to PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1, IF_ID_Flush=0, Pipe_Freeze=0.
- Hazard terms, evaluated only in RUN:
  - match(r) = r!=0 && (r==IF_ID_RegisterRs || (ID_UsesRt && r==IF_ID_RegisterRt)).
  - ldu = ID_EX_MemRead && match(ID_EX_RegisterRd).
  - brEX = ID_Branch && ID_EX_RegWrite && match(ID_EX_RegisterRd).
  - brMEM = ID_Branch && EX_MEM_RegWrite && match(EX_MEM_RegisterRd).
- Required stall count N:
  - N=2 if brEX is true. This covers a branch that depends on a load in EX.
  - Else N=1 if ldu or brMEM is true.
  - Else N=0.
- FSM states: RUN, STALL.
- RUN:
  - If N>0: this cycle is stall cycle 1. Outputs are PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1.
  - If N>0 and N==2: go to STALL with cnt=1.
  - If N>0 and N==1: stay in RUN. Detection re-evaluates next cycle and must find no hazard.
  - If N==0: PC_Write=1, IF_ID_Write=1, ID_EX_Bubble=0.
  - If N==0: IF_ID_Flush = ID_Branch && ID_BranchTaken.
- STALL:
  - Outputs are PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1.
  - cnt decrements. When cnt==0 after the decrement, go to RUN.
  - Hazard inputs are ignored in STALL.
- Flush rules:
  - IF_ID_Flush is never asserted during any stall cycle.
  - IF_ID_Flush is never asserted while Pipe_Freeze=1.
- mem_stall has priority over everything, in any state:
  - Pipe_Freeze=1, PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=0, IF_ID_Flush=0.
  - state and cnt hold. Counters do not count mem_stall cycles.
  - When mem_stall deasserts, the FSM resumes exactly where it stopped.
- Counters:
  - stall_cycles increments on each cycle with ID_EX_Bubble=1 and Pipe_Freeze=0.
  - flush_count increments on each cycle with IF_ID_Flush=1.
  - Both saturate at all-ones.
  - perf_clr zeroes both on the next edge and wins over a simultaneous increment.
- Latency:
  - Control outputs are combinational from state and inputs; there is no added latency.
  - Counters update at the next rising edge.

Test Plan:
- lw $2 in EX, add reads $2 in ID -> 1 cycle with PC_Write=0, ID_EX_Bubble=1; next cycle PC_Write=1; stall_cycles=1.
- add $3 in EX, beq reads $3 in ID -> 2 consecutive stall cycles, then beq taken gives IF_ID_Flush=1 for exactly 1 cycle; stall_cycles=2, flush_count=1.
- beq with Rs=$0 while EX writes $0 -> no stall; destination $0 never matches.
- mem_stall pulsed 3 cycles during the 1st STALL cycle of a brEX hazard -> Pipe_Freeze=1 for 3 cycles; cnt held; then 1 more stall cycle; stall_cycles=2.
- Preload stall_cycles to all-ones, then force one more stall -> value holds; perf_clr together with an increment -> 0.
- rst_n dropped asynchronously mid-STALL -> outputs take reset values immediately; after release with no hazard -> PC_Write=1, state RUN.

Source files
------------

// File: rtl/hazard_stall_ctrl_if.sv
// hazard_stall_ctrl_if: ID-stage hazard inputs, pipeline control outputs and perf counters.
interface hazard_stall_ctrl_if #(parameter int CNT_W = 16);
  logic             ID_EX_MemRead;
  logic             ID_EX_RegWrite;
  logic [4:0]       ID_EX_RegisterRd;
  logic             EX_MEM_RegWrite;
  logic [4:0]       EX_MEM_RegisterRd;
  logic [4:0]       IF_ID_RegisterRs;
  logic [4:0]       IF_ID_RegisterRt;
  logic             ID_UsesRt;
  logic             ID_Branch;
  logic             ID_BranchTaken;
  logic             mem_stall;
  logic             perf_clr;
  logic             PC_Write;
  logic             IF_ID_Write;
  logic             ID_EX_Bubble;
  logic             IF_ID_Flush;
  logic             Pipe_Freeze;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;
  modport master (
    output ID_EX_MemRead, ID_EX_RegWrite, ID_EX_RegisterRd, EX_MEM_RegWrite, EX_MEM_RegisterRd,
           IF_ID_RegisterRs, IF_ID_RegisterRt, ID_UsesRt, ID_Branch, ID_BranchTaken, mem_stall, perf_clr,
    input  PC_Write, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, Pipe_Freeze, stall_cycles, flush_count
  );
  modport slave (
    input  ID_EX_MemRead, ID_EX_RegWrite, ID_EX_RegisterRd, EX_MEM_RegWrite, EX_MEM_RegisterRd,
           IF_ID_RegisterRs, IF_ID_RegisterRt, ID_UsesRt, ID_Branch, ID_BranchTaken, mem_stall, perf_clr,
    output PC_Write, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, Pipe_Freeze, stall_cycles, flush_count
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: ID-stage load-use/branch-operand stall, flush and memory-freeze sequencing.
module hazard_stall_ctrl #(parameter int CNT_W = 16) (
  input logic clk,
  input logic rst_n,
  hazard_stall_ctrl_if.slave hz
);
  typedef enum logic {RUN, STALL} state_t;
  state_t state;
  logic [1:0] cnt;
  logic [CNT_W-1:0] stallCnt, flushCnt;
  logic matchEx, matchMem, ldu, brEx, brMem, stallCyc, frz;
  always_comb begin
    matchEx = hz.ID_EX_RegisterRd != 5'd0 && (hz.ID_EX_RegisterRd == hz.IF_ID_RegisterRs ||
              (hz.ID_UsesRt && hz.ID_EX_RegisterRd == hz.IF_ID_RegisterRt));
    matchMem = hz.EX_MEM_RegisterRd != 5'd0 && (hz.EX_MEM_RegisterRd == hz.IF_ID_RegisterRs ||
               (hz.ID_UsesRt && hz.EX_MEM_RegisterRd == hz.IF_ID_RegisterRt));
    ldu = hz.ID_EX_MemRead && matchEx;
    brEx = hz.ID_Branch && hz.ID_EX_RegWrite && matchEx;
    brMem = hz.ID_Branch && hz.EX_MEM_RegWrite && matchMem;
    stallCyc = state == STALL || (ldu || brEx || brMem);
    frz = rst_n && hz.mem_stall;
  end
  // Reset forces a bubble with PC/IF-ID held; mem_stall overrides every other decision.
  assign hz.Pipe_Freeze  = frz;
  assign hz.PC_Write     = rst_n && !hz.mem_stall && !stallCyc;
  assign hz.IF_ID_Write  = rst_n && !hz.mem_stall && !stallCyc;
  assign hz.ID_EX_Bubble = !rst_n || (!hz.mem_stall && stallCyc);
  assign hz.IF_ID_Flush  = rst_n && !hz.mem_stall && !stallCyc && hz.ID_Branch && hz.ID_BranchTaken;
  assign hz.stall_cycles = stallCnt;
  assign hz.flush_count  = flushCnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt <= 2'd0;
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      if (!hz.mem_stall) begin
        if (state == RUN && brEx) begin
          state <= STALL;
          cnt <= 2'd1;
        end else if (state == STALL) begin
          cnt <= cnt - 2'd1;
          state <= cnt == 2'd1 ? RUN : STALL;
        end
      end
      if (hz.perf_clr) begin
        stallCnt <= '0;
        flushCnt <= '0;
      end else begin
        if (hz.ID_EX_Bubble && !frz && stallCnt != '1) stallCnt <= stallCnt + CNT_W'(1);
        if (hz.IF_ID_Flush && flushCnt != '1) flushCnt <= flushCnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: scoreboard bench; expected control words and counter values are queued at drive time.
module tb_hazard_stall_ctrl;
  localparam int CW = 4;
  localparam int MAXC = (1 << CW) - 1;
  localparam logic [4:0] RUNNING = 5'b11000, STALLED = 5'b00100, FLUSHED = 5'b11010, FROZEN = 5'b00001, RSTV = 5'b00100;
  typedef struct {int sc; int fc;} cnt_t;
  logic clk = 0, rst_n = 0;
  int total = 0, bad = 0, sc = 0, fc = 0;
  logic [4:0] ctlQ[$];
  cnt_t cntQ[$];
  hazard_stall_ctrl_if #(.CNT_W(CW)) hzIf();
  hazard_stall_ctrl #(.CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .hz(hzIf));
  always #5 clk = ~clk;
  function automatic logic [4:0] ctl();
    return {hzIf.PC_Write, hzIf.IF_ID_Write, hzIf.ID_EX_Bubble, hzIf.IF_ID_Flush, hzIf.Pipe_Freeze};
  endfunction
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask
  always @(negedge clk) if (ctlQ.size() != 0) chk("ctl", 32'(ctl()), 32'(ctlQ.pop_front()));
  always @(posedge clk) begin
    #1;
    if (cntQ.size() != 0) begin
      cnt_t e;
      e = cntQ.pop_front();
      chk("stall_cycles", 32'(hzIf.stall_cycles), 32'(e.sc));
      chk("flush_count", 32'(hzIf.flush_count), 32'(e.fc));
    end
  end
  task automatic setIn(input logic mr, rw, input logic [4:0] rd, input logic mrw, input logic [4:0] mrd,
                       input logic [4:0] rs, rt, input logic ut, br, bt);
    hzIf.ID_EX_MemRead = mr; hzIf.ID_EX_RegWrite = rw; hzIf.ID_EX_RegisterRd = rd;
    hzIf.EX_MEM_RegWrite = mrw; hzIf.EX_MEM_RegisterRd = mrd;
    hzIf.IF_ID_RegisterRs = rs; hzIf.IF_ID_RegisterRt = rt; hzIf.ID_UsesRt = ut;
    hzIf.ID_Branch = br; hzIf.ID_BranchTaken = bt;
  endtask
  task automatic idle();
    setIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  // Drives one cycle at posedge+2; the counter model follows the expected control word.
  task automatic cyc(input logic [4:0] exp, input logic ms = 0, input logic clr = 0);
    cnt_t e;
    hzIf.mem_stall = ms;
    hzIf.perf_clr = clr;
    if (clr) begin sc = 0; fc = 0; end
    else begin
      if (exp[2] && !exp[0] && sc < MAXC) sc++;
      if (exp[1] && fc < MAXC) fc++;
    end
    e.sc = sc; e.fc = fc;
    ctlQ.push_back(exp);
    cntQ.push_back(e);
    @(posedge clk);
    #2;
  endtask
  initial begin
    idle();
    hzIf.mem_stall = 0;
    hzIf.perf_clr = 0;
    #1;
    chk("reset_ctl", 32'(ctl()), 32'(RSTV));
    chk("reset_sc", 32'(hzIf.stall_cycles), 0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #2;
    cyc(RUNNING);
    // load-use: lw $2 in EX, add reads $2
    setIn(1, 1, 2, 0, 0, 2, 0, 0, 0, 0); cyc(STALLED);
    setIn(0, 0, 0, 1, 2, 2, 0, 0, 0, 0); cyc(RUNNING);
    // load-use through Rt only when Rt is a source
    setIn(1, 1, 7, 0, 0, 1, 7, 1, 0, 0); cyc(STALLED);
    setIn(1, 1, 7, 0, 0, 1, 7, 0, 0, 0); cyc(RUNNING);
    // brEX: add $3 in EX, beq reads $3 -> two stalls then taken flush
    setIn(0, 1, 3, 0, 0, 3, 0, 0, 1, 1); cyc(STALLED);
    cyc(STALLED);
    setIn(0, 0, 0, 0, 0, 3, 0, 0, 1, 1); cyc(FLUSHED);
    idle(); cyc(RUNNING);
    // $0 never matches, EX or MEM
    setIn(0, 1, 0, 1, 0, 0, 0, 1, 1, 0); cyc(RUNNING);
    // brMEM through Rt: one stall
    setIn(0, 0, 0, 1, 5, 1, 5, 1, 1, 0); cyc(STALLED);
    setIn(0, 0, 0, 0, 0, 1, 5, 1, 1, 1); cyc(FLUSHED);
    // mem_stall during STALL of a brEX hazard: freeze 3, then finish the second stall
    setIn(1, 1, 4, 0, 0, 4, 0, 0, 1, 1); cyc(STALLED);
    idle(); hzIf.ID_Branch = 1; hzIf.ID_BranchTaken = 1;
    repeat (3) cyc(FROZEN, 1);
    cyc(STALLED);
    cyc(FLUSHED);
    // mem_stall in RUN with a hazard present and a taken branch
    setIn(1, 1, 6, 0, 0, 6, 0, 0, 1, 1); cyc(FROZEN, 1);
    idle(); cyc(RUNNING);
    // saturate stall_cycles, then clear over a simultaneous increment
    setIn(1, 1, 2, 0, 0, 2, 0, 0, 0, 0);
    repeat (MAXC + 1) cyc(STALLED);
    cyc(STALLED, 0, 1);
    idle(); cyc(RUNNING);
    // async reset mid-STALL
    setIn(0, 1, 9, 0, 0, 9, 0, 0, 1, 0); cyc(STALLED);
    rst_n = 0;
    #1;
    chk("rst_mid_ctl", 32'(ctl()), 32'(RSTV));
    chk("rst_mid_sc", 32'(hzIf.stall_cycles), 0);
    chk("rst_mid_fc", 32'(hzIf.flush_count), 0);
    sc = 0; fc = 0;
    idle();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #2;
    cyc(RUNNING);
    cyc(RUNNING);
    @(negedge clk);
    chk("queues_drained", 32'(ctlQ.size() + cntQ.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
